circle_sched: RTL



---
 rtl/circle_sched_pkg.sv | 36 +++
 rtl/screen_sweeper.sv | 46 ++++
 rtl/circle_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/circle_sched_pkg.sv
// Shared types and constants for the three-engine circle sequencer.
// The state encoding and screen geometry used by circle_sched and its sweeper.
package circle_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN0  = 3'd2,
        ST_RUN1  = 3'd3,
        ST_RUN2  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int N_ENG    = 3;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_BLUE  = 3'b001;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_RED   = 3'b100;

    // One-hot engine start pattern belonging to a state; zero outside RUNk.
    function automatic logic [N_ENG-1:0] start_decode(input state_e s);
        logic [N_ENG-1:0] r;
        r = 3'b000;
        case (s)
            ST_RUN0: r = 3'b001;
            ST_RUN1: r = 3'b010;
            ST_RUN2: r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/screen_sweeper.sv
// Framebuffer sweep counters: y runs inner over the screen height, x outer.
// last flags the final pixel (159,119); both counters wrap to zero after it.
module screen_sweeper
    import circle_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       last
);

    localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_MAX = 7'(SCREEN_H - 1);

    logic [7:0] x_r;
    logic [6:0] y_r;

    // Advance the sweep position while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= 8'd0;
            y_r <= 7'd0;
        end else if (en) begin
            if (y_r == Y_MAX) begin
                y_r <= 7'd0;
                if (x_r == X_MAX) begin
                    x_r <= 8'd0;
                end else begin
                    x_r <= x_r + 8'd1;
                end
            end else begin
                y_r <= y_r + 7'd1;
            end
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

    assign x    = x_r;
    assign y    = y_r;
    assign last = (x_r == X_MAX) && (y_r == Y_MAX);

endmodule

// File: rtl/circle_sched.sv
// Sequencer for the blue/green/red circle engines: optional black clear, then
// each engine in turn, owning the single VGA write port.
module circle_sched
    import circle_sched_pkg::*;
#(
    parameter bit         CLEAR_EN = 1'b1,
    parameter logic [2:0] COL0     = COL_BLUE,
    parameter logic [2:0] COL1     = COL_GREEN,
    parameter logic [2:0] COL2     = COL_RED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 done,
    output logic [N_ENG-1:0]     eng_start,
    input  logic [N_ENG-1:0]     eng_done,
    input  logic [8*N_ENG-1:0]   eng_x,
    input  logic [7*N_ENG-1:0]   eng_y,
    input  logic [N_ENG-1:0]     eng_plot,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [2:0]           vga_colour,
    output logic                 vga_plot
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             done_r;
    logic [N_ENG-1:0] eng_start_r;
    logic [2:0]       colour_r;
    logic             clear_plot_r;

    logic             sweep_en_s;
    logic [7:0]       sweep_x_s;
    logic [6:0]       sweep_y_s;
    logic             sweep_last_s;

    function automatic logic [2:0] colour_decode(input state_e s);
        logic [2:0] c;
        c = COL_BLACK;
        case (s)
            ST_RUN0: c = COL0;
            ST_RUN1: c = COL1;
            ST_RUN2: c = COL2;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

    assign sweep_en_s = (state_r == ST_CLEAR);

    screen_sweeper u_sweeper (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sweep_en_s),
        .x     (sweep_x_s),
        .y     (sweep_y_s),
        .last  (sweep_last_s)
    );

    // Next-state logic; start dropping mid-figure is deliberately ignored.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = CLEAR_EN ? ST_CLEAR : ST_RUN0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (sweep_last_s) begin
                    state_nxt_s = ST_RUN0;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN0: begin
                if (eng_done[0]) begin
                    state_nxt_s = ST_RUN1;
                end else begin
                    state_nxt_s = ST_RUN0;
                end
            end
            ST_RUN1: begin
                if (eng_done[1]) begin
                    state_nxt_s = ST_RUN2;
                end else begin
                    state_nxt_s = ST_RUN1;
                end
            end
            ST_RUN2: begin
                if (eng_done[2]) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN2;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; outputs are decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            done_r       <= 1'b0;
            eng_start_r  <= 3'b000;
            colour_r     <= 3'b000;
            clear_plot_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            done_r       <= (state_nxt_s == ST_DONE);
            eng_start_r  <= start_decode(state_nxt_s);
            colour_r     <= colour_decode(state_nxt_s);
            clear_plot_r <= (state_nxt_s == ST_CLEAR);
        end
    end

    // Pixel mux: only the active engine reaches the adapter, and its done cycle never plots.
    always_comb begin
        vga_x    = 8'd0;
        vga_y    = 7'd0;
        vga_plot = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                vga_x    = sweep_x_s;
                vga_y    = sweep_y_s;
                vga_plot = clear_plot_r;
            end
            ST_RUN0: begin
                vga_x    = eng_x[7:0];
                vga_y    = eng_y[6:0];
                vga_plot = eng_plot[0] & ~eng_done[0];
            end
            ST_RUN1: begin
                vga_x    = eng_x[15:8];
                vga_y    = eng_y[13:7];
                vga_plot = eng_plot[1] & ~eng_done[1];
            end
            ST_RUN2: begin
                vga_x    = eng_x[23:16];
                vga_y    = eng_y[20:14];
                vga_plot = eng_plot[2] & ~eng_done[2];
            end
            default: begin
                vga_x    = 8'd0;
                vga_y    = 7'd0;
                vga_plot = 1'b0;
            end
        endcase
    end

    assign done       = done_r;
    assign eng_start  = eng_start_r;
    assign vga_colour = colour_r;

endmodule
